// File: rtl/lbp_hist_pkg.sv
// rtl/lbp_hist_pkg.sv - shared state encoding and sizing constants for the LBP histogram
package lbp_hist_pkg;

  localparam int CNT_W_DEF  = 14;
  localparam int EXPECT_DEF = 15876;
  localparam int NUM_BINS   = 256;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lbp_hist_bank.sv
// rtl/lbp_hist_bank.sv - 256-entry bin register file, one saturating-increment/clear write port, one async read port
module lbp_hist_bank
  import lbp_hist_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic             clr_i,
  input  logic [7:0]       waddr_i,
  input  logic [7:0]       raddr_i,
  output logic [CNT_W-1:0] rdata_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bin_q [NUM_BINS];

  // Single write port: clear on drain transfer, otherwise saturating increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        bin_q[i] <= '0;
      end
    end else if (we_i) begin
      if (clr_i) begin
        bin_q[waddr_i] <= '0;
      end else if (bin_q[waddr_i] != CNT_MAX) begin
        bin_q[waddr_i] <= bin_q[waddr_i] + 1'b1;
      end
    end
  end

  assign rdata_o = bin_q[raddr_i];

endmodule

// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - accumulates an LBP code histogram per frame and drains it bin by bin
module lbp_hist
  import lbp_hist_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int EXPECT = EXPECT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  input  logic             hist_ready,
  output logic             hist_valid,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_last,
  output logic             done,
  output logic             err
);

  localparam logic [31:0]      EXPECT_U = 32'(EXPECT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             fin_q;
  logic             err_q, err_d;

  logic             accept;
  logic             xfer;
  logic             fin_rise;
  logic [CNT_W-1:0] rdata;

  assign accept   = (state_q == ST_ACCUM) && lbp_valid;
  assign xfer     = (state_q == ST_DRAIN) && hist_ready;
  assign fin_rise = finish && !fin_q;

  // Bank writes never collide: increments only in ACCUM, clears only in DRAIN
  lbp_hist_bank #(.CNT_W(CNT_W)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we_i    (accept || xfer),
    .clr_i   (xfer),
    .waddr_i (xfer ? idx_q : lbp_data),
    .raddr_i (idx_q),
    .rdata_o (rdata)
  );

  // Next-state: the total includes a strobe coincident with finish before it is checked
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    total_d = (accept && (total_q != CNT_MAX)) ? total_q + 1'b1 : total_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (fin_rise) begin
          state_d = ST_DRAIN;
          if (32'(total_d) != EXPECT_U) err_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'hFF) state_d = ST_DONE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    if (lbp_valid && (state_q != ST_ACCUM)) err_d = 1'b1;
  end

  // State, index, total, finish edge detector and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      total_q <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      fin_q   <= finish;
      err_q   <= err_d;
    end
  end

  assign hist_valid = (state_q == ST_DRAIN);
  assign hist_bin   = idx_q;
  assign hist_count = rdata;
  assign hist_last  = hist_valid && (idx_q == 8'hFF);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - directed self-checking bench for lbp_hist
module tb_lbp_hist;

  logic        clk;
  logic        reset;
  logic        lbp_valid;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_ready;
  logic        hist_valid;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic        hist_last;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int exp_bins [256];

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_ready (hist_ready),
    .hist_valid (hist_valid),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_last  (hist_last),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_bins[i] = 0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    lbp_valid  = 1'b0;
    lbp_data   = 8'h00;
    finish     = 1'b0;
    hist_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int n, input int base, input bit cyc);
    for (int k = 0; k < n; k++) begin
      lbp_valid = 1'b1;
      lbp_data  = cyc ? 8'((base + k) % 256) : 8'(base);
      exp_bins[lbp_data]++;
      @(negedge clk);
    end
    lbp_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int upto);
    for (int i = 0; i < upto; i++) begin
      check("drain_valid", 32'(hist_valid), 32'd1);
      check("drain_bin", 32'(hist_bin), 32'(i));
      check("drain_count", 32'(hist_count), 32'(exp_bins[i]));
      check("drain_last", 32'(hist_last), 32'(i == 255));
      if (toggle) begin
        hist_ready = 1'b0;
        @(negedge clk);
        check("hold_valid", 32'(hist_valid), 32'd1);
        check("hold_bin", 32'(hist_bin), 32'(i));
        check("hold_count", 32'(hist_count), 32'(exp_bins[i]));
        check("hold_last", 32'(hist_last), 32'(i == 255));
      end
      hist_ready = 1'b1;
      @(negedge clk);
    end
    hist_ready = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    lbp_valid  = 1'b0;
    lbp_data   = 8'h00;
    finish     = 1'b0;
    hist_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(hist_valid), 32'd0);
    check("rst_bin", 32'(hist_bin), 32'd0);
    check("rst_count", 32'(hist_count), 32'd0);
    check("rst_last", 32'(hist_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // all-zero codes, full frame
    do_reset();
    clear_exp();
    send(15876, 0, 1'b0);
    check("t33_pre_valid", 32'(hist_valid), 32'd0);
    finish = 1'b1;
    @(negedge clk);
    drain(1'b0, 256);
    check("t33_done", 32'(done), 32'd1);
    check("t33_valid_off", 32'(hist_valid), 32'd0);
    check("t33_err", 32'(err), 32'd0);
    repeat (4) @(negedge clk);
    check("t33_done_hold", 32'(done), 32'd1);
    check("t33_no_redrain", 32'(hist_valid), 32'd0);

    // cycling codes, ready toggling
    do_reset();
    clear_exp();
    send(15876, 0, 1'b1);
    finish = 1'b1;
    @(negedge clk);
    check("t34_bin0_63", 32'(exp_bins[0]), 32'd63);
    check("t34_bin4_62", 32'(exp_bins[4]), 32'd62);
    drain(1'b1, 256);
    check("t34_done", 32'(done), 32'd1);
    check("t34_err", 32'(err), 32'd0);

    // back-to-back hits on one bin, short frame
    do_reset();
    clear_exp();
    send(5, 8'hA5, 1'b0);
    finish = 1'b1;
    @(negedge clk);
    check("t35_err", 32'(err), 32'd1);
    drain(1'b0, 256);
    check("t35_done", 32'(done), 32'd1);

    // strobe coincident with finish edge, latency check
    do_reset();
    clear_exp();
    send(2, 9, 1'b0);
    lbp_valid = 1'b1;
    lbp_data  = 8'd9;
    finish    = 1'b1;
    exp_bins[9]++;
    check("t36_pre_valid", 32'(hist_valid), 32'd0);
    @(negedge clk);
    lbp_valid = 1'b0;
    check("t36_lat_valid", 32'(hist_valid), 32'd1);
    drain(1'b0, 256);
    check("t36_bin9_total", 32'(exp_bins[9]), 32'd3);
    check("t36_err", 32'(err), 32'd1);
    check("t36_done", 32'(done), 32'd1);

    // abort mid-drain, then a clean frame; then strobe during drain
    do_reset();
    clear_exp();
    send(10, 2, 1'b0);
    finish = 1'b1;
    @(negedge clk);
    drain(1'b0, 3);
    do_reset();
    check("t37_rst_valid", 32'(hist_valid), 32'd0);
    check("t37_rst_err", 32'(err), 32'd0);
    clear_exp();
    send(15876, 1, 1'b0);
    finish = 1'b1;
    @(negedge clk);
    check("t37_err_entry", 32'(err), 32'd0);
    lbp_valid = 1'b1;
    lbp_data  = 8'd1;
    @(negedge clk);
    lbp_valid = 1'b0;
    check("t38_err", 32'(err), 32'd1);
    check("t38_bin_hold", 32'(hist_bin), 32'd0);
    drain(1'b0, 256);
    check("t37_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have parameter CNT_W, default 14, bin-count width.
REQ-002 SHALL have parameter EXPECT, default 15876, number of LBP codes expected per frame (126x126).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port lbp_valid  input  1  one-cycle strobe qualifying lbp_data from the LBP stage.
REQ-006 SHALL have port lbp_data  input  8  LBP code, used as bin index.
REQ-007 SHALL have port finish  input  1  LBP frame complete; level, stays high once set.
REQ-008 SHALL have port hist_ready  input  1  downstream accepts the current bin.
REQ-009 SHALL have port hist_valid  output  1  hist_bin and hist_count are valid.
REQ-010 SHALL have port hist_bin  output  8  bin index being output.
REQ-011 SHALL have port hist_count  output  CNT_W  count of that bin.
REQ-012 SHALL have port hist_last  output  1  high with hist_valid for bin 255.
REQ-013 SHALL have port done  output  1  high once all 256 bins have been accepted, held until reset.
REQ-014 SHALL have port err  output  1  sticky: total count != EXPECT, or lbp_valid seen outside ACCUM.

Function
REQ-015 SHALL implement states ACCUM, DRAIN, DONE; reset enters ACCUM.
REQ-016 In ACCUM, lbp_valid SHALL increment bin[lbp_data] by 1 in that cycle, visible the next cycle; back-to-back strobes, including to the same bin, SHALL all be counted.
REQ-017 Bin increments SHALL saturate at 2^CNT_W-1.
REQ-018 A CNT_W-bit total counter SHALL count accepted strobes, saturating.
REQ-019 ACCUM->DRAIN SHALL occur on the rising edge of finish (finish high, registered finish low).
REQ-020 lbp_valid in the same cycle as the finish rising edge SHALL be counted before draining.
REQ-021 On entry to DRAIN, the total SHALL be compared with EXPECT; on mismatch err SHALL be set.
REQ-022 In DRAIN, hist_valid SHALL be high with hist_bin = index, starting at 0, and hist_count = bin[index].
REQ-023 A transfer SHALL occur when hist_valid and hist_ready are both high; the bin SHALL then be cleared to 0 and index incremented.
REQ-024 When hist_ready is low, hist_bin, hist_count and hist_valid SHALL hold stable.
REQ-025 A transfer with index 255 SHALL move to DONE: hist_valid low, done high.
REQ-026 lbp_valid in DRAIN or DONE SHALL be ignored for counting and SHALL set err.
REQ-027 DONE SHALL be terminal until reset; finish remaining high SHALL cause no new drain.
REQ-028 Output latency from the finish rising edge to first hist_valid SHALL be 1 cycle.

Reset
REQ-029 Reset SHALL asynchronously clear all 256 bins, total, index, registered finish, err and done, and set hist_valid=0, hist_last=0, hist_bin=0, hist_count=0.
REQ-030 Reset asserted mid-ACCUM or mid-DRAIN SHALL abort the frame; the next frame starts with all bins at zero.

Structure
REQ-031 A shared package SHALL hold the state encoding, the CNT_W default, EXPECT, and NUM_BINS=256.
REQ-032 The bin array SHALL be a register file inside a sub-module lbp_hist_bank with a one-write-port increment/clear and one combinational read port.

Verification
REQ-033 Reset, 15876 strobes all lbp_data=8'h00, finish -> bin0 count 15876, bins 1-255 count 0, err=0, done after 256 transfers.
REQ-034 Strobes codes 0..255 cycling, 15876 total, hist_ready toggling 1/0 -> each bin 62 or 63 (bins 0-3 = 63), outputs stable while ready is low, hist_last only on bin 255.
REQ-035 Back-to-back strobes, 5 consecutive cycles with code 8'hA5, then finish -> bin 0xA5 = 5, err=1 (total != EXPECT).
REQ-036 Strobe coincident with the finish rising edge -> counted; first hist_valid one cycle later.
REQ-037 Reset pulse after 3 drained bins, then a new frame of 15876 strobes with code 8'h01 -> bin1=15876, all other bins 0.
REQ-038 Strobe during DRAIN -> err=1, counts unchanged.
